// File: rtl/dpa_share_encoder.sv
// dpa_share_encoder
//   Splits a plaintext word into NUMBER_OF_SHARES Boolean shares whose XOR is
//   the plaintext. Shares 1..N-1 are fresh mask bits collected from an
//   external RNG. Share 0 is the plaintext XOR all the mask shares. The data
//   register and the mask buffer are cleared after every encode. q is cleared
//   after every output handshake.
//
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   in_data/valid/ready   plaintext word input handshake
//   rnd_data/valid/ready  RNG beat input handshake (RNG_WIDTH bits per beat)
//   q/out_valid/out_ready shares out; share s is q[s*DATA_WIDTH +: DATA_WIDTH]
//
// Build option
//   DPA_ENCODER_PREFETCH_EN: masks are gathered ahead of time, after reset and
//   after each output handshake. A word is then accepted in READY and goes
//   straight to ENCODE. When the macro is undefined, masks are gathered only
//   after a word has been accepted.
module dpa_share_encoder #(
  parameter int NUMBER_OF_SHARES = 3,
  parameter int DATA_WIDTH       = 8,
  parameter int RNG_WIDTH        = 8
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic [DATA_WIDTH-1:0]                  in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [RNG_WIDTH-1:0]                   rnd_data,
  input  logic                                   rnd_valid,
  output logic                                   rnd_ready,
  output logic [NUMBER_OF_SHARES*DATA_WIDTH-1:0] q,
  output logic                                   out_valid,
  input  logic                                   out_ready
);

  localparam int          MASK_BITS = (NUMBER_OF_SHARES - 1) * DATA_WIDTH;
  localparam int          BEATS     = (MASK_BITS > 0) ?
                                      (MASK_BITS + RNG_WIDTH - 1) / RNG_WIDTH : 0;
  // The mask buffer keeps at least one share of width so that the
  // single-share build still elaborates cleanly.
  localparam int          MASK_W    = (MASK_BITS > 0) ? MASK_BITS : DATA_WIDTH;
  localparam int          CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int          Q_W       = NUMBER_OF_SHARES * DATA_WIDTH;
  localparam int unsigned NS        = NUMBER_OF_SHARES;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((BEATS > 0) ? BEATS - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATHER,
    ST_ENCODE,
    ST_OUTPUT,
    ST_PREFETCH,
    ST_READY
  } state_t;

`ifdef DPA_ENCODER_PREFETCH_EN
  localparam state_t RESET_ST = ST_PREFETCH;
  localparam state_t AFTER_OUT = ST_PREFETCH;
`else
  localparam state_t RESET_ST = ST_IDLE;
  localparam state_t AFTER_OUT = ST_IDLE;
`endif

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [MASK_W-1:0]     mask_q,  mask_d;
  logic [CNT_W-1:0]      beat_q,  beat_d;
  logic [Q_W-1:0]        q_q,     q_d;

  logic [MASK_W-1:0]     beat_ext;
  logic [DATA_WIDTH-1:0] share0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_ST;
      data_q  <= '0;
      mask_q  <= '0;
      beat_q  <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      beat_q  <= beat_d;
      q_q     <= q_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    beat_d   = beat_q;
    q_d      = q_q;
    share0   = data_q;
    // The beat is placed at its LSB-first slot. Shifting inside a
    // MASK_W-wide vector drops the bits of the last beat that fall beyond
    // MASK_BITS. The buffer is all-zero between words, so OR is enough to
    // merge the beat in.
    beat_ext = MASK_W'(rnd_data) << (int'(beat_q) * RNG_WIDTH);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          beat_d  = '0;
          state_d = (BEATS == 0) ? ST_ENCODE : ST_GATHER;
        end
      end
      ST_GATHER: begin
        if (rnd_valid) begin
          mask_d = mask_q | beat_ext;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        for (int unsigned s = 1; s < NS; s++) begin
          q_d[s*DATA_WIDTH +: DATA_WIDTH] = mask_q[(s-1)*DATA_WIDTH +: DATA_WIDTH];
          share0 = share0 ^ mask_q[(s-1)*DATA_WIDTH +: DATA_WIDTH];
        end
        q_d[DATA_WIDTH-1:0] = share0;
        data_d  = '0;
        mask_d  = '0;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          q_d     = '0;
          beat_d  = '0;
          state_d = AFTER_OUT;
        end
      end
`ifdef DPA_ENCODER_PREFETCH_EN
      ST_PREFETCH: begin
        if (BEATS == 0) begin
          state_d = ST_READY;
        end else if (rnd_valid) begin
          mask_d = mask_q | beat_ext;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = ST_ENCODE;
        end
      end
`endif
      default: state_d = RESET_ST;
    endcase
  end

  // Handshake outputs are decoded from state only.
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    rnd_ready = (state_q == ST_GATHER);
`ifdef DPA_ENCODER_PREFETCH_EN
    in_ready  = in_ready  || (state_q == ST_READY);
    rnd_ready = rnd_ready || ((state_q == ST_PREFETCH) && (BEATS != 0));
`endif
    out_valid = (state_q == ST_OUTPUT);
    q         = q_q;
  end

endmodule

// File: tb/tb_dpa_share_encoder.sv
module tb_dpa_share_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared drive, gated to the DUT selected by sel
  logic [7:0] drv_in_data   = '0;
  logic       drv_in_valid  = 1'b0;
  logic [7:0] drv_rnd_data  = '0;
  logic       drv_rnd_valid = 1'b0;
  logic       drv_out_ready = 1'b0;
  int         sel = 0;

  logic [7:0] beats [8];
  int tests = 0;
  int fails = 0;

  // A: defaults, B: RNG_WIDTH = 5, C: one share
  logic        a_in_valid, a_in_ready, a_rnd_valid, a_rnd_ready, a_out_valid, a_out_ready;
  logic [23:0] a_q;
  logic        b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid, b_out_ready;
  logic [23:0] b_q;
  logic        c_in_valid, c_in_ready, c_rnd_valid, c_rnd_ready, c_out_valid, c_out_ready;
  logic [7:0]  c_q;

  assign a_in_valid  = drv_in_valid  && (sel == 0);
  assign a_rnd_valid = drv_rnd_valid && (sel == 0);
  assign a_out_ready = drv_out_ready && (sel == 0);
  assign b_in_valid  = drv_in_valid  && (sel == 1);
  assign b_rnd_valid = drv_rnd_valid && (sel == 1);
  assign b_out_ready = drv_out_ready && (sel == 1);
  assign c_in_valid  = drv_in_valid  && (sel == 2);
  assign c_rnd_valid = drv_rnd_valid && (sel == 2);
  assign c_out_ready = drv_out_ready && (sel == 2);

  dpa_share_encoder #(.NUMBER_OF_SHARES(3), .DATA_WIDTH(8), .RNG_WIDTH(8)) u_a (
    .clock(clk), .reset_n(rst_n), .in_data(drv_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .rnd_data(drv_rnd_data), .rnd_valid(a_rnd_valid),
    .rnd_ready(a_rnd_ready), .q(a_q), .out_valid(a_out_valid), .out_ready(a_out_ready));

  dpa_share_encoder #(.NUMBER_OF_SHARES(3), .DATA_WIDTH(8), .RNG_WIDTH(5)) u_b (
    .clock(clk), .reset_n(rst_n), .in_data(drv_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .rnd_data(drv_rnd_data[4:0]), .rnd_valid(b_rnd_valid),
    .rnd_ready(b_rnd_ready), .q(b_q), .out_valid(b_out_valid), .out_ready(b_out_ready));

  dpa_share_encoder #(.NUMBER_OF_SHARES(1), .DATA_WIDTH(8), .RNG_WIDTH(8)) u_c (
    .clock(clk), .reset_n(rst_n), .in_data(drv_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .rnd_data(drv_rnd_data), .rnd_valid(c_rnd_valid),
    .rnd_ready(c_rnd_ready), .q(c_q), .out_valid(c_out_valid), .out_ready(c_out_ready));

  logic        cur_in_ready, cur_rnd_ready, cur_out_valid;
  logic [23:0] cur_q;
  always_comb begin
    cur_in_ready  = a_in_ready;
    cur_rnd_ready = a_rnd_ready;
    cur_out_valid = a_out_valid;
    cur_q         = a_q;
    if (sel == 1) begin
      cur_in_ready  = b_in_ready;
      cur_rnd_ready = b_rnd_ready;
      cur_out_valid = b_out_valid;
      cur_q         = b_q;
    end else if (sel == 2) begin
      cur_in_ready  = c_in_ready;
      cur_rnd_ready = c_rnd_ready;
      cur_out_valid = c_out_valid;
      cur_q         = {16'h0, c_q};
    end
  end

  // Reference: concatenate the beats LSB-first, keep the first (n-1)*dw
  // bits as the mask, slice it into shares 1..n-1, and make share 0 the
  // data XOR every mask share.
  function automatic logic [23:0] ref_q(input int n, input int dw, input int rw,
                                        input logic [7:0] d, input int nb);
    longint unsigned mask = 0;
    longint unsigned res  = 0;
    longint unsigned s0   = longint'(d);
    longint unsigned sh;
    int mbits = (n - 1) * dw;
    for (int k = 0; k < nb; k++)
      mask = mask | ((longint'(beats[k]) & ((64'd1 << rw) - 1)) << (k * rw));
    mask = (mbits > 0) ? (mask & ((64'd1 << mbits) - 1)) : 0;
    for (int s = 1; s < n; s++) begin
      sh  = (mask >> ((s - 1) * dw)) & ((64'd1 << dw) - 1);
      s0  = s0 ^ sh;
      res = res | (sh << (s * dw));
    end
    res = res | s0;
    return res[23:0];
  endfunction

  // Runs one word on the selected DUT. Inputs and checks happen on falling
  // edges. lat counts rising edges from the accept edge (inclusive) to the
  // edge that raises out_valid.
  task automatic run_word(input logic [7:0] d, input int nbeats, input int stall,
                          input int bp, input int idle_junk,
                          output int lat, output logic [23:0] qv, output int consumed,
                          output int leak, output int holdbad, output int tmo);
    int k = 0;
    int stall_left = stall;
    int w = 0;
    lat = -1; qv = '0; consumed = 0; leak = 0; holdbad = 0; tmo = 0;
    drv_out_ready = 1'b0;
    repeat (idle_junk) begin
      @(negedge clk);
      drv_rnd_valid = 1'b1;
      drv_rnd_data  = 8'($urandom);
      if (cur_rnd_ready) consumed++;
    end
    @(negedge clk);
    drv_rnd_valid = 1'b1;
    drv_rnd_data  = 8'($urandom);
    drv_in_data   = d;
    drv_in_valid  = 1'b1;
    while (!cur_in_ready && w < 20) begin
      if (cur_rnd_ready) consumed++;
      @(negedge clk);
      w++;
    end
    if (cur_rnd_ready) consumed++;
    if (!cur_in_ready) begin
      drv_in_valid = 1'b0; drv_rnd_valid = 1'b0; tmo = 1;
      return;
    end
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      drv_in_valid = 1'b0;
      if (cur_out_valid) begin
        lat = cyc;
        break;
      end
      if (cur_q !== 24'h0) leak++;
      if (k == 1 && stall_left > 0) begin
        drv_rnd_valid = 1'b0;
        stall_left--;
      end else begin
        drv_rnd_valid = 1'b1;
        drv_rnd_data  = (k < nbeats) ? beats[k] : 8'($urandom);
        if (cur_rnd_ready) begin
          consumed++;
          k++;
        end
      end
    end
    if (lat < 0) begin
      drv_rnd_valid = 1'b0; tmo = 1;
      return;
    end
    qv = cur_q;
    // RNG keeps offering beats while the result waits, which must be ignored
    drv_rnd_valid = 1'b1;
    drv_rnd_data  = 8'($urandom);
    repeat (bp) begin
      @(negedge clk);
      if (cur_rnd_ready) consumed++;
      if (cur_q !== qv || !cur_out_valid || cur_in_ready || cur_rnd_ready) holdbad++;
    end
    drv_out_ready = 1'b1;
    @(negedge clk);
    drv_out_ready = 1'b0;
    drv_rnd_valid = 1'b0;
    if (cur_q !== 24'h0 || cur_out_valid || !cur_in_ready) holdbad++;
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (cur_out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b expected 0", cur_out_valid); end
    tests++; if (cur_q !== 24'h0) begin fails++; $display("FAIL rst_q: got %h expected 000000", cur_q); end
    tests++; if (cur_rnd_ready !== 1'b0) begin fails++; $display("FAIL rst_rnd_ready: got %b expected 0", cur_rnd_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (cur_in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b expected 1", cur_in_ready); end
  endtask

  task automatic test_defaults();
    int lat, cons, leak, hb, tmo;
    logic [23:0] qv, exp;
    sel = 0;
    beats[0] = 8'h3C; beats[1] = 8'h5A;
    exp = ref_q(3, 8, 8, 8'hA5, 2);
    run_word(8'hA5, 2, 0, 0, 0, lat, qv, cons, leak, hb, tmo);
    tests++; if (qv !== exp) begin fails++; $display("FAIL def_q: got %h expected %h", qv, exp); end
    tests++; if ((qv[7:0] ^ qv[15:8] ^ qv[23:16]) !== 8'hA5) begin fails++; $display("FAIL def_xor: got %h expected a5", qv[7:0] ^ qv[15:8] ^ qv[23:16]); end
    tests++; if (lat !== 4) begin fails++; $display("FAIL def_latency: got %0d expected 4", lat); end
    tests++; if (cons !== 2) begin fails++; $display("FAIL def_beats: got %0d expected 2", cons); end
    tests++; if (leak !== 0 || hb !== 0 || tmo !== 0) begin fails++; $display("FAIL def_clean: got leak=%0d hold=%0d tmo=%0d expected 0", leak, hb, tmo); end
  endtask

  task automatic test_backpressure();
    int lat, cons, leak, hb, tmo;
    logic [23:0] qv, exp;
    sel = 0;
    beats[0] = 8'h3C; beats[1] = 8'h5A;
    exp = ref_q(3, 8, 8, 8'hA5, 2);
    run_word(8'hA5, 2, 0, 5, 0, lat, qv, cons, leak, hb, tmo);
    tests++; if (qv !== exp) begin fails++; $display("FAIL bp_q: got %h expected %h", qv, exp); end
    tests++; if (hb !== 0 || tmo !== 0) begin fails++; $display("FAIL bp_hold: got hold=%0d tmo=%0d expected 0", hb, tmo); end
    tests++; if (cons !== 2) begin fails++; $display("FAIL bp_beats: got %0d expected 2", cons); end
  endtask

  task automatic test_rng_stall();
    int lat, cons, leak, hb, tmo;
    logic [23:0] qv, exp;
    sel = 0;
    beats[0] = 8'h3C; beats[1] = 8'h5A;
    exp = ref_q(3, 8, 8, 8'hA5, 2);
    run_word(8'hA5, 2, 3, 0, 3, lat, qv, cons, leak, hb, tmo);
    tests++; if (qv !== exp) begin fails++; $display("FAIL stall_q: got %h expected %h", qv, exp); end
    tests++; if (lat !== 7) begin fails++; $display("FAIL stall_latency: got %0d expected 7", lat); end
    tests++; if (cons !== 2) begin fails++; $display("FAIL stall_beats: got %0d expected 2", cons); end
  endtask

  task automatic test_random();
    int lat, cons, leak, hb, tmo, st, bp;
    logic [23:0] qv, exp;
    logic [7:0] d;
    sel = 0;
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      beats[0] = 8'($urandom); beats[1] = 8'($urandom);
      st = int'($urandom_range(0, 2));
      bp = int'($urandom_range(0, 2));
      exp = ref_q(3, 8, 8, d, 2);
      run_word(d, 2, st, bp, int'($urandom_range(0, 2)), lat, qv, cons, leak, hb, tmo);
      tests++;
      if (qv !== exp || lat !== 4 + st || cons !== 2 || leak !== 0 || hb !== 0 || tmo !== 0) begin
        fails++;
        $display("FAIL rand_word%0d: got q=%h lat=%0d beats=%0d leak=%0d hold=%0d tmo=%0d expected q=%h lat=%0d beats=2",
                 i, qv, lat, cons, leak, hb, tmo, exp, 4 + st);
      end
    end
  endtask

  task automatic test_partial_beat();
    int lat, cons, leak, hb, tmo;
    logic [23:0] qv, exp;
    logic [7:0] d;
    sel = 1;
    beats[0] = 8'h1F; beats[1] = 8'h00; beats[2] = 8'h15; beats[3] = 8'h0A;
    exp = ref_q(3, 8, 5, 8'h00, 4);
    run_word(8'h00, 4, 0, 0, 0, lat, qv, cons, leak, hb, tmo);
    tests++; if (qv !== exp) begin fails++; $display("FAIL part_q: got %h expected %h", qv, exp); end
    tests++; if (cons !== 4) begin fails++; $display("FAIL part_beats: got %0d expected 4", cons); end
    tests++; if (lat !== 6) begin fails++; $display("FAIL part_latency: got %0d expected 6", lat); end
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      for (int k = 0; k < 4; k++) beats[k] = 8'($urandom_range(0, 31));
      exp = ref_q(3, 8, 5, d, 4);
      run_word(d, 4, 1, 1, 0, lat, qv, cons, leak, hb, tmo);
      tests++;
      if (qv !== exp || cons !== 4 || hb !== 0 || tmo !== 0) begin
        fails++;
        $display("FAIL part_rand%0d: got q=%h beats=%0d hold=%0d tmo=%0d expected q=%h beats=4", i, qv, cons, hb, tmo, exp);
      end
    end
  endtask

  task automatic test_single_share();
    int lat, cons, leak, hb, tmo;
    logic [23:0] qv, exp;
    sel = 2;
    exp = ref_q(1, 8, 8, 8'h3E, 0);
    run_word(8'h3E, 0, 0, 0, 2, lat, qv, cons, leak, hb, tmo);
    tests++; if (qv !== exp) begin fails++; $display("FAIL one_q: got %h expected %h", qv, exp); end
    tests++; if (lat !== 2) begin fails++; $display("FAIL one_latency: got %0d expected 2", lat); end
    tests++; if (cons !== 0) begin fails++; $display("FAIL one_beats: got %0d expected 0", cons); end
  endtask

  task automatic test_reset_mid_gather();
    int lat, cons, leak, hb, tmo, seen;
    logic [23:0] qv, exp;
    sel = 0;
    @(negedge clk);
    drv_in_data = 8'h77; drv_in_valid = 1'b1;
    @(negedge clk);
    drv_in_valid = 1'b0; drv_rnd_valid = 1'b1; drv_rnd_data = 8'h99;
    @(negedge clk);
    drv_rnd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (cur_q !== 24'h0 || cur_out_valid !== 1'b0 || cur_rnd_ready !== 1'b0) begin
      fails++;
      $display("FAIL midrst_outputs: got q=%h ov=%b rr=%b expected 000000 0 0", cur_q, cur_out_valid, cur_rnd_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (cur_out_valid || cur_q !== 24'h0) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_stale: got %0d stale cycles expected 0", seen); end
    beats[0] = 8'h11; beats[1] = 8'h22;
    exp = ref_q(3, 8, 8, 8'h0F, 2);
    run_word(8'h0F, 2, 0, 0, 0, lat, qv, cons, leak, hb, tmo);
    tests++; if (qv !== exp) begin fails++; $display("FAIL midrst_q: got %h expected %h", qv, exp); end
    tests++; if (lat !== 4 || cons !== 2) begin fails++; $display("FAIL midrst_flow: got lat=%0d beats=%0d expected 4 2", lat, cons); end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_backpressure();
    test_rng_stall();
    test_random();
    test_partial_beat();
    test_single_share();
    test_reset_mid_gather();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
